// File: rtl/multiword_add_seq_pkg.sv
// Shared constants and FSM encoding for the multi-word add/subtract sequencer.
package multiword_add_seq_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multiword_add_seq_carrysel.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputing its sum for
// carry-in 0 and 1, with the incoming block carry selecting the result.
module sixteenbit_carrysel
    import multiword_add_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] x,
    input  logic [LIMB_W-1:0] y,
    input  logic              cin,
    output logic [LIMB_W-1:0] sum,
    output logic              cout
);

    localparam int BLK_W = 4;
    localparam int N_BLK = LIMB_W / BLK_W;

    logic [N_BLK:0] blk_c;

    assign blk_c[0] = cin;

    for (genvar g = 0; g < N_BLK; g++) begin : g_blk
        logic [BLK_W:0] sum_c0;
        logic [BLK_W:0] sum_c1;

        assign sum_c0 = {1'b0, x[g*BLK_W +: BLK_W]} + {1'b0, y[g*BLK_W +: BLK_W]};
        assign sum_c1 = {1'b0, x[g*BLK_W +: BLK_W]} + {1'b0, y[g*BLK_W +: BLK_W]}
                        + {{BLK_W{1'b0}}, 1'b1};

        assign sum[g*BLK_W +: BLK_W] = blk_c[g] ? sum_c1[BLK_W-1:0] : sum_c0[BLK_W-1:0];
        assign blk_c[g+1]            = blk_c[g] ? sum_c1[BLK_W]     : sum_c0[BLK_W];
    end

    assign cout = blk_c[N_BLK];

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-word add/subtract sequencer. Streams one 16-bit limb per cycle through
// a single carry-select adder, LSB limb first, chaining the carry between limbs.
//
// state | meaning
// IDLE  | op_ready high, waiting for an operand request
// RUN   | one limb per clock through the adder, carry held in carry_q
// DONE  | res_valid high, result held until res_ready
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int LIMBS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [16*LIMBS-1:0]   op_a,
    input  logic [16*LIMBS-1:0]   op_b,
    input  logic                  op_cin,
    input  logic                  op_sub,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [16*LIMBS-1:0]   res_sum,
    output logic                  res_cout,
    output logic                  res_ovf
);

    localparam int W     = LIMB_W * LIMBS;
    localparam int CNT_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(LIMBS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       res_sum_q, res_sum_d;
    logic               res_cout_q, res_cout_d;
    logic               res_ovf_q, res_ovf_d;
    logic               op_ready_q, op_ready_d;
    logic               res_valid_q, res_valid_d;

    logic [LIMB_W-1:0]  add_x;
    logic [LIMB_W-1:0]  add_y;
    logic [LIMB_W-1:0]  add_sum;
    logic               add_cout;

    // Select the current limb of the captured operands for the shared adder.
    always_comb begin
        add_x = '0;
        add_y = '0;
        for (int i = 0; i < LIMBS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                add_x = a_q[i*LIMB_W +: LIMB_W];
                add_y = b_q[i*LIMB_W +: LIMB_W];
            end
        end
    end

    sixteenbit_carrysel u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state, datapath and registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        op_ready_d  = op_ready_q;
        res_valid_d = res_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid && op_ready_q) begin
                    a_d         = op_a;
                    b_d         = op_sub ? ~op_b : op_b;
                    carry_d     = op_sub ? 1'b1 : op_cin;
                    res_sum_d   = '0;
                    res_cout_d  = 1'b0;
                    res_ovf_d   = 1'b0;
                    cnt_d       = '0;
                    op_ready_d  = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < LIMBS; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        res_sum_d[i*LIMB_W +: LIMB_W] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (cnt_q == LAST_LIMB) begin
                    // Overflow: carry out of the sign bit differs from carry into it.
                    res_cout_d  = add_cout;
                    res_ovf_d   = add_cout ^ (add_x[LIMB_W-1] ^ add_y[LIMB_W-1] ^ add_sum[LIMB_W-1]);
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                op_ready_d  = 1'b1;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed testbench for multiword_add_seq with LIMBS=4 (64-bit operands).
module tb_multiword_add_seq;

    localparam int LIMBS = 4;
    localparam int W     = 16 * LIMBS;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         op_sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ovf;

    int n_cmp = 0;
    int n_err = 0;

    multiword_add_seq #(.LIMBS(LIMBS)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .op_sub    (op_sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge. Presents one request, checks it is accepted
    // and that res_valid rises exactly LIMBS edges after the accept edge.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        int cyc;
        check({tag, "_op_ready"}, 64'(op_ready), 64'd1);
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        op_sub   = sub;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
            if (res_valid) break;
        end
        if (!res_valid) cyc = 99;
        check({tag, "_latency"}, 64'(cyc), 64'(LIMBS));
    endtask

    // Called #1 after a rising edge while in DONE: drain the result.
    task automatic drain(input string tag);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, "_drain_ready"}, 64'(op_ready), 64'd1);
        check({tag, "_drain_valid"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        op_sub    = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_op_ready", 64'(op_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_sum", res_sum, 64'd0);
        check("rst_res_cout", 64'(res_cout), 64'd0);
        check("rst_res_ovf", 64'(res_ovf), 64'd0);

        // Carry from limb 0 into limb 1
        run_op("t1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        check("t1_sum", res_sum, 64'h0000_0000_0001_0000);
        check("t1_cout", 64'(res_cout), 64'd0);
        check("t1_ovf", 64'(res_ovf), 64'd0);
        drain("t1");

        // Carry ripples through every limb
        run_op("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        check("t2_sum", res_sum, 64'h0);
        check("t2_cout", 64'(res_cout), 64'd1);
        check("t2_ovf", 64'(res_ovf), 64'd0);
        drain("t2");

        // Signed overflow at the top limb
        run_op("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        check("t3_sum", res_sum, 64'h8000_0000_0000_0000);
        check("t3_cout", 64'(res_cout), 64'd0);
        check("t3_ovf", 64'(res_ovf), 64'd1);
        drain("t3");

        // Subtract with borrow; op_cin must be ignored
        run_op("t4a", 64'd5, 64'd7, 1'b1, 1'b1);
        check("t4a_sum", res_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t4a_cout", 64'(res_cout), 64'd0);
        check("t4a_ovf", 64'(res_ovf), 64'd0);
        drain("t4a");

        run_op("t4b", 64'd7, 64'd5, 1'b0, 1'b1);
        check("t4b_sum", res_sum, 64'h2);
        check("t4b_cout", 64'(res_cout), 64'd1);
        check("t4b_ovf", 64'(res_ovf), 64'd0);
        drain("t4b");

        // Backpressure: hold in DONE while op_* wiggle
        run_op("t5", 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            op_valid = ~op_valid;
            op_a     = 64'(i) * 64'h0101_0101_0101_0101;
            @(posedge clk);
            #1;
            check("t5_hold_sum", res_sum, 64'h0011_0022_0033_0044);
            check("t5_hold_valid", 64'(res_valid), 64'd1);
            check("t5_hold_ready", 64'(op_ready), 64'd0);
            check("t5_hold_cout", 64'(res_cout), 64'd0);
        end
        // res_ready together with op_valid in DONE: request must not be taken
        op_valid  = 1'b1;
        op_a      = 64'd100;
        op_b      = 64'd23;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        check("t5_exit_ready", 64'(op_ready), 64'd1);
        check("t5_exit_valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        #1;
        check("t5_not_taken", 64'(op_ready), 64'd1);
        run_op("t5b", 64'd100, 64'd23, 1'b0, 1'b0);
        check("t5b_sum", res_sum, 64'd123);
        drain("t5b");

        // Reset after two RUN cycles aborts the operation
        op_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b     = 64'h1;
        op_cin   = 1'b0;
        op_sub   = 1'b0;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_op_ready", 64'(op_ready), 64'd1);
        check("t6_res_valid", 64'(res_valid), 64'd0);
        check("t6_res_sum", res_sum, 64'd0);
        check("t6_res_cout", 64'(res_cout), 64'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("t6_no_pulse", 64'(res_valid), 64'd0);
        end
        run_op("t6b", 64'd1, 64'd2, 1'b0, 1'b0);
        check("t6b_sum", res_sum, 64'd3);
        check("t6b_cout", 64'(res_cout), 64'd0);
        drain("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
